// File: rtl/fetch_pkg.sv
// Shared fetch/decode types: one queued instruction and the queue geometry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int FQ_FETCH_WIDTH = 2;
  localparam int FQ_ADDR_WIDTH  = 32;
  localparam int FQ_DEPTH       = 8;
  localparam int FQ_DEQ_WIDTH   = 2;

  // One buffered instruction with its own PC, as decode sees it.
  typedef struct packed {
    logic [31:0]              inst;
    logic [FQ_ADDR_WIDTH-1:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction buffer between IFU and decode: whole fetch bundles in, up to DEQ_WIDTH oldest out.
// Latency: an accepted bundle is visible on the out slots the cycle after it is written; outputs are combinational from storage.
// Backpressure: in_ready drops when a full bundle no longer fits (registered count only); decode over-requests are clamped.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int FETCH_WIDTH     = FQ_FETCH_WIDTH,
  parameter int INST_ADDR_WIDTH = FQ_ADDR_WIDTH,
  parameter int DEQ_WIDTH       = FQ_DEQ_WIDTH,
  parameter int DEPTH           = FQ_DEPTH
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [INST_ADDR_WIDTH-1:0]                in_pc,
  input  logic [FETCH_WIDTH-1:0][31:0]              in_inst,
  output logic [DEQ_WIDTH-1:0]                      out_valid,
  output logic [DEQ_WIDTH-1:0][31:0]                out_inst,
  output logic [DEQ_WIDTH-1:0][INST_ADDR_WIDTH-1:0] out_pc,
  input  logic [$clog2(DEQ_WIDTH+1)-1:0]            deq_count,
  output logic [$clog2(DEPTH+1)-1:0]                count,
  output logic                                      empty,
  output logic                                      full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] avail;
  logic [CNT_W-1:0] eff;
  logic [CNT_W-1:0] count_nxt;
  logic             enq;

  // Only the registered count gates acceptance, so slots freed by this
  // cycle's dequeue become usable next cycle; keeps in_ready off the decode path.
  assign free_slots = CNT_W'(DEPTH) - count_q;
  assign in_ready   = free_slots >= CNT_W'(FETCH_WIDTH);
  assign enq        = in_valid & in_ready & ~flush;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Clamp decode's request to what is actually presented, then form next occupancy.
  always_comb begin
    avail     = (count_q > CNT_W'(DEQ_WIDTH)) ? CNT_W'(DEQ_WIDTH) : count_q;
    eff       = (CNT_W'(deq_count) > avail) ? avail : CNT_W'(deq_count);
    count_nxt = count_q + (enq ? CNT_W'(FETCH_WIDTH) : '0) - eff;
  end

  // Present the oldest entries; empty slots drive zeros so decode never sees stale data.
  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    for (int j = 0; j < DEQ_WIDTH; j++) begin
      if (count_q > CNT_W'(j)) begin
        out_valid[j] = 1'b1;
        out_inst[j]  = mem[head + PTR_W'(j)].inst;
        out_pc[j]    = mem[head + PTR_W'(j)].pc;
      end
    end
  end

  // Pointers and occupancy; flush empties the queue exactly like reset does.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        tail <= tail + PTR_W'(FETCH_WIDTH);
      end
      head    <= head + PTR_W'(eff);
      count_q <= count_nxt;
    end
  end

  // Split the bundle into per-instruction entries; PCs step by 4 and wrap at the PC width.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        mem[tail + PTR_W'(i)] <= '{inst: in_inst[i],
                                   pc:   in_pc + INST_ADDR_WIDTH'(4 * i)};
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (FETCH_WIDTH=2, DEQ_WIDTH=2, DEPTH=8).
// A negedge scoreboard tracks every accepted instruction; vector tables and
// short hand sequences check occupancy, flow control, flush and reset.
module tb_fetch_queue;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [1:0][31:0] in_inst;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_inst;
  logic [1:0][31:0] out_pc;
  logic [1:0]       deq_count;
  logic [3:0]       count;
  logic             empty;
  logic             full;

  always #5 clk = ~clk;

  fetch_queue #(
    .FETCH_WIDTH(2), .INST_ADDR_WIDTH(32), .DEQ_WIDTH(2), .DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .deq_count(deq_count), .count(count), .empty(empty), .full(full)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;

  sb_t sbq[$];
  bit  mon_en  = 1'b0;
  int  overdeq = 0;
  int  m_sz, m_avail, m_eff, m_vld;
  bit  m_enq;

  // Mid-cycle: compare DUT state with the model, then advance the model
  // by what the upcoming edge will do with the current inputs.
  always @(negedge clk) begin
    if (mon_en) begin
      m_sz = sbq.size();
      chk("sb_count", 32'(count), 32'(m_sz));
      chk("sb_in_ready", 32'(in_ready), 32'((8 - m_sz) >= 2));
      chk("sb_empty", 32'(empty), 32'(m_sz == 0));
      chk("sb_full", 32'(full), 32'(m_sz == 8));
      for (int j = 0; j < 2; j++) begin
        if (j < m_sz) begin
          chk($sformatf("sb_valid%0d", j), 32'(out_valid[j]), 32'd1);
          chk($sformatf("sb_pc%0d", j), out_pc[j], sbq[j].pc);
          chk($sformatf("sb_inst%0d", j), out_inst[j], sbq[j].inst);
        end else begin
          chk($sformatf("sb_valid%0d", j), 32'(out_valid[j]), 32'd0);
          chk($sformatf("sb_pc%0d", j), out_pc[j], 32'd0);
          chk($sformatf("sb_inst%0d", j), out_inst[j], 32'd0);
        end
      end
      // Decode asking for more than is presented is a decode-side bug; record it.
      m_vld = int'(out_valid[0]) + int'(out_valid[1]);
      if (!reset && !flush && int'(deq_count) > m_vld) overdeq++;
      if (reset || flush) begin
        sbq.delete();
      end else begin
        m_avail = (m_sz < 2) ? m_sz : 2;
        m_eff   = (int'(deq_count) > m_avail) ? m_avail : int'(deq_count);
        m_enq   = in_valid && ((8 - m_sz) >= 2);
        repeat (m_eff) void'(sbq.pop_front());
        if (m_enq) begin
          sbq.push_back('{pc: in_pc, inst: in_inst[0]});
          sbq.push_back('{pc: in_pc + 32'd4, inst: in_inst[1]});
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    bit          fl;
    bit          v;
    logic [31:0] pc;
    int          deq;
    int          e_cnt;
    bit          e_rdy;
    bit          e_full;
    bit          e_empty;
    logic [1:0]  e_ov;
  } vec_t;

  vec_t vt[$];
  int   vec_no = 0;

  task automatic addv(input bit rst, input bit fl, input bit v, input logic [31:0] pc,
                      input int deq, input int c, input bit rdy, input bit f,
                      input bit e, input logic [1:0] ov);
    vt.push_back('{rst, fl, v, pc, deq, c, rdy, f, e, ov});
  endtask

  task automatic drive(input bit rst, input bit fl, input bit v, input logic [31:0] pc,
                       input int deq);
    reset      = rst;
    flush      = fl;
    in_valid   = v;
    in_pc      = pc;
    in_inst[0] = ~pc;
    in_inst[1] = ~(pc + 32'd4);
    deq_count  = 2'(deq);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 0);
  endtask

  task automatic run_vecs();
    foreach (vt[k]) begin
      drive(vt[k].rst, vt[k].fl, vt[k].v, vt[k].pc, vt[k].deq);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", vec_no), 32'(count), 32'(vt[k].e_cnt));
      chk($sformatf("v%0d_in_ready", vec_no), 32'(in_ready), 32'(vt[k].e_rdy));
      chk($sformatf("v%0d_full", vec_no), 32'(full), 32'(vt[k].e_full));
      chk($sformatf("v%0d_empty", vec_no), 32'(empty), 32'(vt[k].e_empty));
      chk($sformatf("v%0d_out_valid", vec_no), 32'(out_valid), 32'(vt[k].e_ov));
      vec_no++;
    end
    vt.delete();
    idle();
  endtask

  logic [31:0] exp_pc;
  int          od0;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 0);
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset state, then a single bundle becomes visible next cycle.
    addv(1, 0, 0, 32'h0,   0, 0, 1, 0, 1, 2'b00);
    addv(0, 0, 1, 32'h100, 0, 2, 1, 0, 0, 2'b11);
    run_vecs();
    chk("t1_pc0", out_pc[0], 32'h100);
    chk("t1_pc1", out_pc[1], 32'h104);
    chk("t1_inst0", out_inst[0], ~32'h100);
    chk("t1_inst1", out_inst[1], ~32'h104);

    // Fill to full, a 5th bundle is refused, one dequeue reopens the input.
    addv(0, 0, 1, 32'h108, 0, 4, 1, 0, 0, 2'b11);
    addv(0, 0, 1, 32'h110, 0, 6, 1, 0, 0, 2'b11);
    addv(0, 0, 1, 32'h118, 0, 8, 0, 1, 0, 2'b11);
    addv(0, 0, 1, 32'h120, 0, 8, 0, 1, 0, 2'b11);
    addv(0, 0, 0, 32'h0,   2, 6, 1, 0, 0, 2'b11);
    run_vecs();

    // Over-request with one entry left: clamped to one, flagged.
    addv(1, 0, 0, 32'h0,   0, 0, 1, 0, 1, 2'b00);
    addv(0, 0, 1, 32'h1fc, 0, 2, 1, 0, 0, 2'b11);
    addv(0, 0, 0, 32'h0,   1, 1, 1, 0, 0, 2'b01);
    run_vecs();
    chk("t3_pc0", out_pc[0], 32'h200);
    od0 = overdeq;
    addv(0, 0, 0, 32'h0,   2, 0, 1, 0, 1, 2'b00);
    run_vecs();
    chk("t3_overdeq_flag", 32'(overdeq), 32'(od0 + 1));

    // Steady enqueue + dequeue across the pointer wrap.
    addv(1, 0, 0, 32'h0,   0, 0, 1, 0, 1, 2'b00);
    addv(0, 0, 1, 32'h100, 0, 2, 1, 0, 0, 2'b11);
    addv(0, 0, 1, 32'h108, 0, 4, 1, 0, 0, 2'b11);
    run_vecs();
    exp_pc = 32'h100;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("t4_pc0_c%0d", k), out_pc[0], exp_pc);
      chk($sformatf("t4_pc1_c%0d", k), out_pc[1], exp_pc + 32'd4);
      drive(1'b0, 1'b0, 1'b1, 32'h110 + 32'(8 * k), 2);
      @(posedge clk);
      #1;
      chk($sformatf("t4_count_c%0d", k), 32'(count), 32'd4);
      exp_pc = exp_pc + 32'd8;
    end
    idle();

    // Flush beats a same-cycle enqueue and dequeue; refill afterwards.
    addv(1, 0, 0, 32'h0,   0, 0, 1, 0, 1, 2'b00);
    addv(0, 0, 1, 32'h100, 0, 2, 1, 0, 0, 2'b11);
    addv(0, 0, 1, 32'h108, 0, 4, 1, 0, 0, 2'b11);
    addv(0, 0, 1, 32'h110, 0, 6, 1, 0, 0, 2'b11);
    addv(0, 1, 1, 32'h500, 2, 0, 1, 0, 1, 2'b00);
    addv(0, 0, 1, 32'h400, 0, 2, 1, 0, 0, 2'b11);
    run_vecs();
    chk("t5_pc0", out_pc[0], 32'h400);
    chk("t5_pc1", out_pc[1], 32'h404);

    // Reset in mid-stream with five entries drops everything.
    addv(0, 0, 1, 32'h100, 0, 4, 1, 0, 0, 2'b11);
    addv(0, 0, 1, 32'h108, 0, 6, 1, 0, 0, 2'b11);
    addv(0, 0, 0, 32'h0,   1, 5, 1, 0, 0, 2'b11);
    addv(1, 0, 1, 32'h600, 1, 0, 1, 0, 1, 2'b00);
    run_vecs();
    chk("t6_pc0", out_pc[0], 32'h0);
    chk("t6_pc1", out_pc[1], 32'h0);
    chk("t6_inst0", out_inst[0], 32'h0);
    chk("t6_inst1", out_inst[1], 32'h0);

    @(posedge clk);
    #1;
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
